// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesting units (master) and the arbiter (slave).
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_v;
  logic       switch;

  modport master (output req, input gnt, gnt_id, gnt_v, switch);
  modport slave  (input req, output gnt, gnt_id, gnt_v, switch);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way arbiter: rotated priority encode, grant hold while requested, optional hold timeout.
// Handshake: req is a level; a requester owns the resource while gnt[k]=1 and releases it by dropping req[k].
module rr_arbiter4 #(
  parameter bit RR       = 1'b1,
  parameter int MAX_HOLD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus,
  output logic          dbg_state
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] hold_cnt, cnt_nxt;
  logic [3:0] gnt_q, gnt_nxt;
  logic [1:0] id_q, id_nxt;
  logic       gnt_v_q, gnt_v_nxt;
  logic       sw_q, sw_nxt;

  logic [3:0] others;
  logic [2:0] pick_all, pick_oth;
  logic       take;
  logic [1:0] take_id;

  // Returns {valid, index}: first set bit of r scanning from p upward, mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] enc;
    dbl = {r, r} >> p;
    rot = dbl[3:0];
    casez (rot)
      4'b???1: enc = 2'd0;
      4'b??10: enc = 2'd1;
      4'b?100: enc = 2'd2;
      default: enc = 2'd3;
    endcase
    return {|r, enc + p};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt_q    <= 4'd0;
      id_q     <= 2'd0;
      gnt_v_q  <= 1'b0;
      sw_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= cnt_nxt;
      gnt_q    <= gnt_nxt;
      id_q     <= id_nxt;
      gnt_v_q  <= gnt_v_nxt;
      sw_q     <= sw_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    sw_nxt    = 1'b0;
    take      = 1'b0;
    take_id   = 2'd0;
    // Masking the holder keeps it from winning its own handover.
    others    = bus.req & ~gnt_q;
    pick_all  = pick(bus.req, ptr);
    pick_oth  = pick(others, ptr);
    case (state)
      IDLE: begin
        if (pick_all[2]) begin
          take    = 1'b1;
          take_id = pick_all[1:0];
        end
      end
      GRANT: begin
        if (!bus.req[id_q]) begin
          if (pick_oth[2]) begin
            take    = 1'b1;
            take_id = pick_oth[1:0];
          end else begin
            state_nxt = IDLE;
            id_nxt    = 2'd0;
            cnt_nxt   = 8'd0;
          end
        end else if (TIMEOUT_EN && hold_cnt >= HOLD_LAST) begin
          if (pick_oth[2]) begin
            take    = 1'b1;
            take_id = pick_oth[1:0];
          end else begin
            cnt_nxt = HOLD_LAST;
          end
        end else if (hold_cnt != 8'hff) begin
          cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      state_nxt = GRANT;
      id_nxt    = take_id;
      sw_nxt    = 1'b1;
      cnt_nxt   = 8'd0;
      ptr_nxt   = RR ? take_id + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    gnt_v_nxt = (state_nxt == GRANT);
    gnt_nxt   = gnt_v_nxt ? (4'b0001 << id_nxt) : 4'b0000;
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = id_q;
  assign bus.gnt_v  = gnt_v_q;
  assign bus.switch = sw_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: four configurations share one req/reset stream and are checked against a reference model.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0;

  always #5 clk = ~clk;

  rr_arbiter4_if if0 ();
  rr_arbiter4_if if1 ();
  rr_arbiter4_if if2 ();
  rr_arbiter4_if if3 ();
  logic [3:0] dbg;

  assign if0.req = req;
  assign if1.req = req;
  assign if2.req = req;
  assign if3.req = req;

  rr_arbiter4 #(.RR(1'b1), .MAX_HOLD(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .dbg_state(dbg[0]));
  rr_arbiter4 #(.RR(1'b0), .MAX_HOLD(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .dbg_state(dbg[1]));
  rr_arbiter4 #(.RR(1'b1), .MAX_HOLD(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .dbg_state(dbg[2]));
  rr_arbiter4 #(.RR(1'b1), .MAX_HOLD(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .dbg_state(dbg[3]));

  logic [8:0] act [4];
  assign act[0] = {dbg[0], if0.switch, if0.gnt_v, if0.gnt_id, if0.gnt};
  assign act[1] = {dbg[1], if1.switch, if1.gnt_v, if1.gnt_id, if1.gnt};
  assign act[2] = {dbg[2], if2.switch, if2.gnt_v, if2.gnt_id, if2.gnt};
  assign act[3] = {dbg[3], if3.switch, if3.gnt_v, if3.gnt_id, if3.gnt};

  // Reference model: holder index (-1 when idle), priority pointer, cycles held.
  int cfg_rr [4] = '{1, 0, 1, 1};
  int cfg_mh [4] = '{0, 0, 3, 2};
  int holder [4] = '{-1, -1, -1, -1};
  int ptr_m  [4] = '{0, 0, 0, 0};
  int held   [4] = '{0, 0, 0, 0};

  logic [35:0] exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (p + i) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input bit rs);
    logic [35:0] e;
    for (int c = 0; c < 4; c++) begin
      int w;
      int h;
      bit sw;
      logic [3:0] oth;
      sw = 1'b0;
      w  = -1;
      h  = holder[c];
      if (!rs) begin
        holder[c] = -1;
        ptr_m[c]  = 0;
        held[c]   = 0;
      end else if (h < 0) begin
        w = pick(r, ptr_m[c]);
      end else begin
        oth = r;
        oth[h] = 1'b0;
        if (!r[h]) begin
          w = pick(oth, ptr_m[c]);
          if (w < 0) begin
            holder[c] = -1;
            held[c]   = 0;
          end
        end else if (cfg_mh[c] != 0 && held[c] + 1 >= cfg_mh[c] && oth != 4'd0) begin
          w = pick(oth, ptr_m[c]);
        end else begin
          held[c] = held[c] + 1;
        end
      end
      if (w >= 0) begin
        holder[c] = w;
        held[c]   = 0;
        sw        = 1'b1;
        ptr_m[c]  = (cfg_rr[c] != 0) ? (w + 1) % 4 : 0;
      end
      if (holder[c] < 0) e[c*9 +: 9] = 9'd0;
      else e[c*9 +: 9] = {1'b1, sw, 1'b1, 2'(holder[c]), 4'(1 << holder[c])};
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and record what the next rising edge must produce.
  task automatic step(input logic [3:0] r, input bit rs);
    @(negedge clk);
    req   = r;
    rst_n = rs;
    model_edge(r, rs);
  endtask

  task automatic hold(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [35:0] e;
      e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        total++;
        if (act[c] !== e[c*9 +: 9]) begin
          bad++;
          $display("FAIL cfg%0d outputs {dbg,switch,gnt_v,gnt_id,gnt} t=%0t: got %b want %b",
                   c, $time, act[c], e[c*9 +: 9]);
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    int waited;

    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    hold(4'b0000, 3);

    // Rotation: each holder drops one cycle after its grant, rejoins after handover.
    step(4'b1111, 1'b1);
    step(4'b1110, 1'b1);
    step(4'b1101, 1'b1);
    step(4'b1011, 1'b1);
    step(4'b0111, 1'b1);
    hold(4'b1111, 2);
    hold(4'b0000, 2);

    // Fixed-priority pattern.
    hold(4'b1010, 3);
    hold(4'b1000, 2);
    hold(4'b1011, 2);
    hold(4'b0011, 2);
    hold(4'b0000, 2);

    // Hold timeout with a late contender.
    step(4'b0100, 1'b1);
    hold(4'b0101, 10);
    hold(4'b0000, 2);

    // Timeout with no contender, then a late arrival.
    hold(4'b0010, 10);
    hold(4'b1010, 3);
    hold(4'b0000, 2);

    // Reset in the middle of a grant.
    hold(4'b0100, 2);
    step(4'b1111, 1'b0);
    hold(4'b1111, 3);
    hold(4'b0000, 2);

    r = 4'd0;
    for (int i = 0; i < 500; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
      step(r, ($urandom_range(59, 0) != 0));
    end
    hold(4'b0000, 2);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
